mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

- Two-master arbiter sharing the single Avalon-style memory bus (address/read/write/waitrequest/writedata/byteenable/readdata) between the CPU data port (m0) and instruction-fetch port (m1).
- Sits between the CPU bus masters and the memory or testbench RAM.
- Serialises transfers with a registered FSM: one outstanding transfer at a time, read data returned one cycle after slave acceptance.

## Interface
Parameters:
- AW, 32, address width (byte address, passed through unmodified)
- DW, 32, data width; byteenable width is DW/8

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset
- m0_address / m1_address  in  AW  master byte address
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DW  write data
- m0_byteenable / m1_byteenable  in  DW/8  byte lanes, passed through unchanged (4'b0000 is forwarded as-is)
- m0_waitrequest / m1_waitrequest  out  1  low only in the completion cycle of that master's transfer
- m0_readdata / m1_readdata  out  DW  read data, valid when that master's waitrequest is low after a read
- s_address  out  AW  slave address
- s_read / s_write  out  1  slave strobes
- s_writedata  out  DW  slave write data
- s_byteenable  out  DW/8  slave byte lanes
- s_waitrequest  in  1  slave stall
- s_readdata  in  DW  slave read data, valid the cycle after the read is accepted
- grant  out  2  one-hot current owner (bit0 = m0), 0 when idle

## Operation
- FSM states: IDLE, BUS, RDATA, DONE.
- IDLE:
  - A master requests when its read or write is high.
  - If any master requests, choose a winner (see Configuration), latch its address/writedata/byteenable/op, set grant, go to BUS.
  - If a master asserts both read and write, the transfer is a write.
- BUS:
  - Drive s_* from the latched values; s_read or s_write is high.
  - Stay while s_waitrequest=1.
  - When s_waitrequest=0: a write goes to DONE, a read goes to RDATA.
- RDATA:
  - Strobes low.
  - Capture s_readdata into the granted master's readdata register; go to DONE.
- DONE:
  - Granted master's waitrequest is 0 for exactly one cycle; go to IDLE and clear grant.
- The non-granted master's waitrequest stays 1 throughout.
- The latched transfer always completes, even if the master drops its request mid-transfer.
- mN_readdata holds its last captured value until the next read by that master.
- Reset (reset=0 at a clock edge), including mid-transfer:
  - State = IDLE.
  - s_read=s_write=0; s_address, s_writedata, s_byteenable = 0.
  - Both waitrequest = 1; both readdata = 0; grant = 0.
  - Round-robin pointer set so m0 wins the first tie.

## Timing
- Request sampled in IDLE at edge N: s_read/s_write high from cycle N+1.
- Zero-wait write: DONE in cycle N+2, IDLE in N+3.
- Zero-wait read: RDATA in N+2, DONE with valid readdata in N+3, IDLE in N+4.
- Each slave wait cycle adds one cycle in BUS.
- Requests are not sampled in BUS, RDATA or DONE.
- A master still requesting during another master's transfer is evaluated in the following IDLE cycle.
- Minimum issue interval: 3 cycles (write), 4 cycles (read).

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - On simultaneous requests, grant the master not granted last; the pointer updates on each grant.
  - A lone requester is always granted.
- Undefined: fixed priority, m0 always wins a tie; m1 can starve.

## Test plan
- Single read: m0_read, address 32'hBFC0002C; slave returns 32'h000000F3 with 0 wait cycles -> s_read high exactly 1 cycle; m0_waitrequest low in cycle N+3 with m0_readdata=32'h000000F3; grant back to 0 at N+4.
- Byte write with stall: m1_write, byteenable 4'b0100, writedata 32'h000000F3; s_waitrequest high for 3 cycles -> s_write held 4 cycles with stable address/data/byteenable; m1_waitrequest low exactly once, at N+5.
- Simultaneous continuous requests from both masters:
  - With ARB_ROUND_ROBIN_EN: grants alternate m0, m1, m0, m1.
  - Without it: m0 granted every time, m1 never.
- Read+write asserted together by m0 -> s_write=1, s_read=0 throughout.
- reset=0 asserted while in BUS with s_waitrequest=1 -> next cycle all strobes 0, grant=0, both waitrequest=1; no DONE pulse.
- m0 drops read after 1 BUS cycle -> transfer still completes and returns readdata; m1 is then granted normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter : two-master Avalon-style bus arbiter, one transfer at a time.
// Optional `ARB_ROUND_ROBIN_EN: round-robin tie-break (otherwise fixed, m0 wins).
// Revision: 1.0
// ============================================================================
module mem_bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   m0_address,
  input  logic            m0_read,
  input  logic            m0_write,
  input  logic [DW-1:0]   m0_writedata,
  input  logic [DW/8-1:0] m0_byteenable,
  output logic            m0_waitrequest,
  output logic [DW-1:0]   m0_readdata,
  input  logic [AW-1:0]   m1_address,
  input  logic            m1_read,
  input  logic            m1_write,
  input  logic [DW-1:0]   m1_writedata,
  input  logic [DW/8-1:0] m1_byteenable,
  output logic            m1_waitrequest,
  output logic [DW-1:0]   m1_readdata,
  output logic [AW-1:0]   s_address,
  output logic            s_read,
  output logic            s_write,
  output logic [DW-1:0]   s_writedata,
  output logic [DW/8-1:0] s_byteenable,
  input  logic            s_waitrequest,
  input  logic [DW-1:0]   s_readdata,
  output logic [1:0]      grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    RDATA = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [1:0]        grant_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q;
  logic [DW/8-1:0]   be_q;
  logic              write_q;
  logic [DW-1:0]     rdata0_q, rdata1_q;
  logic              req0, req1, pick1, load;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

`ifdef ARB_ROUND_ROBIN_EN
  // last_m1 remembers the previous winner; reset value lets m0 win the first tie.
  logic last_m1;

  always_ff @(posedge clk) begin
    if (!reset)
      last_m1 <= 1'b1;
    else if (load)
      last_m1 <= pick1;
  end

  always_comb begin
    pick1 = req1 & ~req0;
    if (req0 && req1)
      pick1 = ~last_m1;
  end
`else
  always_comb begin
    pick1 = req1 & ~req0;
  end
`endif

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_next = BUS;
          load       = 1'b1;
        end
      end
      BUS: begin
        if (!s_waitrequest)
          state_next = write_q ? DONE : RDATA;
      end
      RDATA:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      grant_q  <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      write_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        // A write request takes precedence when a master raises read and write together.
        grant_q <= pick1 ? 2'b10 : 2'b01;
        addr_q  <= pick1 ? m1_address    : m0_address;
        wdata_q <= pick1 ? m1_writedata  : m0_writedata;
        be_q    <= pick1 ? m1_byteenable : m0_byteenable;
        write_q <= pick1 ? m1_write      : m0_write;
      end else if (state == DONE) begin
        grant_q <= 2'b00;
      end
      if (state == RDATA) begin
        if (grant_q[0]) rdata0_q <= s_readdata;
        if (grant_q[1]) rdata1_q <= s_readdata;
      end
    end
  end

  assign s_address      = addr_q;
  assign s_writedata    = wdata_q;
  assign s_byteenable   = be_q;
  assign s_read         = (state == BUS) & ~write_q;
  assign s_write        = (state == BUS) &  write_q;
  assign grant          = grant_q;
  assign m0_waitrequest = ~((state == DONE) & grant_q[0]);
  assign m1_waitrequest = ~((state == DONE) & grant_q[1]);
  assign m0_readdata    = rdata0_q;
  assign m1_readdata    = rdata1_q;

endmodule
`default_nettype wire
